// File: rtl/quad_decode_bank_if.sv
// Command/response byte link between the SPI slave and the encoder bank.
// The master drives cmd/cmd_valid; the slave returns a registered response byte.
interface quad_decode_bank_if;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic [7:0] response;

  modport master (output cmd, output cmd_valid, input response);
  modport slave  (input cmd, input cmd_valid, output response);
endinterface

// File: rtl/quad_decode_bank.sv
// Multi-channel x4 quadrature decoder: sync + glitch filter (2+FILT_LEN clks), response 1 clk after cmd_valid,
// no back-pressure (one command per pulse). Optional Z index channel under ENC_INDEX_EN.
module quad_decode_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int FILT_LEN  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
`ifdef ENC_INDEX_EN
  input  logic [NUM_CH-1:0] enc_z,
`endif
  quad_decode_bank_if.slave bus,
  output logic [NUM_CH-1:0] err
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0]    idx_flag;
  logic                 snap_cmd;
  logic                 clr_cmd;
  logic [63:0]          rd_word;
  logic [7:0]           rd_byte;

  assign snap_cmd = bus.cmd_valid && (bus.cmd[7:6] == 2'b01);
  assign clr_cmd  = bus.cmd_valid && (bus.cmd[7:6] == 2'b10);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]           a_sync;
    logic [1:0]           b_sync;
    logic [1:0]           ab_filt;
    logic [1:0]           ab_new;
    logic [3:0]           fcnt;
    logic                 armed;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] shadow_q;
    logic                 err_q;
    logic                 ab_upd;
    logic                 step_fwd;
    logic                 step_rev;
    logic                 clr_hit;
    logic                 z_rise;

    assign ab_new   = {a_sync[1], b_sync[1]};
    assign ab_upd   = (ab_new != ab_filt) && (fcnt == FILT_LAST);
    // Gray order 00->01->11->10: a single-bit move is either one step forward or one back
    assign step_fwd = (ab_new == {ab_filt[0], ~ab_filt[1]});
    assign step_rev = (ab_new == {~ab_filt[0], ab_filt[1]});
    assign clr_hit  = clr_cmd && (bus.cmd[5:3] == 3'(g));

`ifdef ENC_INDEX_EN
    logic [1:0] z_sync;
    logic       z_filt;
    logic [3:0] z_fcnt;
    logic       z_upd;
    logic       idx_q;

    assign z_upd  = (z_sync[1] != z_filt) && (z_fcnt == FILT_LAST);
    assign z_rise = z_upd && z_sync[1];
    assign idx_flag[g] = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_sync <= '0;
        z_filt <= 1'b0;
        z_fcnt <= '0;
        idx_q  <= 1'b0;
      end else begin
        z_sync <= {z_sync[0], enc_z[g]};
        if (z_upd) begin
          z_filt <= z_sync[1];
          z_fcnt <= '0;
        end else if (z_sync[1] != z_filt) begin
          z_fcnt <= z_fcnt + 4'd1;
        end else begin
          z_fcnt <= '0;
        end
        if (clr_hit)     idx_q <= 1'b0;
        else if (z_rise) idx_q <= 1'b1;
      end
    end
`else
    assign z_rise      = 1'b0;
    assign idx_flag[g] = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_sync   <= '0;
        b_sync   <= '0;
        ab_filt  <= '0;
        fcnt     <= '0;
        armed    <= 1'b0;
        cnt_q    <= '0;
        shadow_q <= '0;
        err_q    <= 1'b0;
      end else begin
        a_sync <= {a_sync[0], enc_a[g]};
        b_sync <= {b_sync[0], enc_b[g]};
        if (ab_upd) begin
          ab_filt <= ab_new;
          fcnt    <= '0;
          if (!armed)        armed <= 1'b1;
          else if (step_fwd) cnt_q <= cnt_q + CNT_WIDTH'(1);
          else if (step_rev) cnt_q <= cnt_q - CNT_WIDTH'(1);
          else               err_q <= 1'b1;
        end else if (ab_new != ab_filt) begin
          fcnt <= fcnt + 4'd1;
        end else begin
          fcnt <= '0;
        end
        // Later assignments take priority: index beats a step, clear beats everything
        if (z_rise) cnt_q <= '0;
        if (clr_hit) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        if (snap_cmd) shadow_q <= cnt_q;
      end
    end

    assign shadow[g] = shadow_q;
    assign err[g]    = err_q;
  end

  // Zero-extension to 64 bits makes out-of-range bytes and channels read as 0x00
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cmd[5:3] == 3'(i)) rd_word = 64'(shadow[i]);
    end
  end
  assign rd_byte = rd_word[{bus.cmd[2:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.response <= 8'h00;
    end else if (bus.cmd_valid) begin
      case (bus.cmd[7:6])
        2'b00:   bus.response <= rd_byte;
        2'b01:   bus.response <= 8'hA5;
        2'b10:   bus.response <= 8'h00;
        default: bus.response <= bus.cmd[0] ? 8'(idx_flag) : 8'(err);
      endcase
    end
  end

endmodule
